// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_e;

  localparam int CNT_W    = 3;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection between fetch and data requesters: data first, but fetch
// is forced through once data has won STARVE_MAX times in a row over it.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d,
  output logic [STREAK_W-1:0] streak_next
);

  always_comb begin
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    streak_next = streak;
    if (i_req && d_req) begin
      if (streak == STREAK_W'(STARVE_MAX)) grant_i = 1'b1;
      else                                 grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end

    // Streak only counts data wins that actually made fetch wait.
    if (grant_i)      streak_next = '0;
    else if (grant_d) streak_next = i_req ? streak + STREAK_W'(1) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; one
// transaction in flight, fixed MEM_LAT response latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  state_e              state_q;
  own_e                own_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  logic pick_i;
  logic pick_d;
  logic grant_slot;
  logic complete;

  mem_arb_picker #(
    .STARVE_MAX(STARVE_MAX)
  ) u_picker (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak     (streak_q),
    .grant_i    (pick_i),
    .grant_d    (pick_d),
    .streak_next(streak_d)
  );

  // The completion cycle doubles as a grant slot so back-to-back accesses
  // run at one per MEM_LAT cycles.
  assign complete   = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
  assign grant_slot = (state_q == ST_IDLE) || complete;

  assign i_ready  = grant_slot && pick_i;
  assign d_ready  = grant_slot && pick_d;
  assign m_en     = i_ready || d_ready;
  assign m_we     = d_ready && d_we;
  assign m_addr   = d_ready ? d_addr : (i_ready ? i_addr : '0);
  assign m_wdata  = d_ready ? d_wdata : '0;

  assign i_rvalid = complete && (own_q == OWN_I);
  assign d_rvalid = complete && (own_q == OWN_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = we_q ? '0 : m_rdata;
  assign busy     = (state_q == ST_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      own_q    <= OWN_I;
      we_q     <= 1'b0;
      streak_q <= '0;
    end else if (grant_slot) begin
      if (m_en) begin
        state_q  <= ST_WAIT;
        cnt_q    <= CNT_W'(MEM_LAT);
        own_q    <= d_ready ? OWN_D : OWN_I;
        we_q     <= m_we;
        streak_q <= streak_d;
      end else begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances with MEM_LAT = 1, 2, 3 (index 0..2).
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;

  logic        i_req   [3];
  logic [31:0] i_addr  [3];
  logic        i_ready [3];
  logic        i_rvalid[3];
  logic [31:0] i_rdata [3];
  logic        d_req   [3];
  logic        d_we    [3];
  logic [31:0] d_addr  [3];
  logic [31:0] d_wdata [3];
  logic        d_ready [3];
  logic        d_rvalid[3];
  logic [31:0] d_rdata [3];
  logic        m_en    [3];
  logic        m_we    [3];
  logic [31:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  logic [31:0] m_rdata [3];
  logic        busy    [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(g + 1), .STARVE_MAX(4)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req[g]),
      .i_addr  (i_addr[g]),
      .i_ready (i_ready[g]),
      .i_rvalid(i_rvalid[g]),
      .i_rdata (i_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_ready (d_ready[g]),
      .d_rvalid(d_rvalid[g]),
      .d_rdata (d_rdata[g]),
      .m_en    (m_en[g]),
      .m_we    (m_we[g]),
      .m_addr  (m_addr[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g]),
      .busy    (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; m_rdata[k] = '0;
    end

    // Reset state
    tick(); tick(); settle();
    check("rst_i_ready",  {31'b0, i_ready[1]},  0);
    check("rst_d_ready",  {31'b0, d_ready[1]},  0);
    check("rst_i_rvalid", {31'b0, i_rvalid[1]}, 0);
    check("rst_d_rvalid", {31'b0, d_rvalid[1]}, 0);
    check("rst_m_en",     {31'b0, m_en[1]},     0);
    check("rst_m_we",     {31'b0, m_we[1]},     0);
    check("rst_busy",     {31'b0, busy[1]},     0);
    check("rst_m_addr",   m_addr[1],  0);
    check("rst_m_wdata",  m_wdata[1], 0);
    tick();
    reset = 1'b1;
    tick();

    // Single fetch, MEM_LAT=2
    i_req[1] = 1'b1; i_addr[1] = 32'h0; m_rdata[1] = 32'h2002_0005;
    settle();
    check("f1_c0_i_ready", {31'b0, i_ready[1]}, 1);
    check("f1_c0_m_en",    {31'b0, m_en[1]},    1);
    check("f1_c0_m_addr",  m_addr[1], 32'h0);
    check("f1_c0_busy",    {31'b0, busy[1]},    0);
    tick(); i_req[1] = 1'b0; settle();
    check("f1_c1_busy",    {31'b0, busy[1]},     1);
    check("f1_c1_i_rvalid",{31'b0, i_rvalid[1]}, 0);
    check("f1_c1_m_en",    {31'b0, m_en[1]},     0);
    tick(); settle();
    check("f1_c2_i_rvalid",{31'b0, i_rvalid[1]}, 1);
    check("f1_c2_i_rdata", i_rdata[1], 32'h2002_0005);
    check("f1_c2_busy",    {31'b0, busy[1]},     1);
    tick(); settle();
    check("f1_c3_busy",    {31'b0, busy[1]},     0);
    check("f1_c3_i_rvalid",{31'b0, i_rvalid[1]}, 0);

    // Simultaneous fetch + load, MEM_LAT=2: data first
    i_req[1] = 1'b1; i_addr[1] = 32'h40;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h1000;
    m_rdata[1] = 32'hDEAD_0001;
    settle();
    check("pr_c0_d_ready", {31'b0, d_ready[1]}, 1);
    check("pr_c0_i_ready", {31'b0, i_ready[1]}, 0);
    check("pr_c0_m_addr",  m_addr[1], 32'h1000);
    tick(); d_req[1] = 1'b0; settle();
    check("pr_c1_i_ready", {31'b0, i_ready[1]}, 0);
    tick(); settle();
    check("pr_c2_d_rvalid",{31'b0, d_rvalid[1]}, 1);
    check("pr_c2_d_rdata", d_rdata[1], 32'hDEAD_0001);
    check("pr_c2_i_ready", {31'b0, i_ready[1]}, 1);
    check("pr_c2_m_addr",  m_addr[1], 32'h40);
    tick(); i_req[1] = 1'b0; settle();
    check("pr_c3_i_rvalid",{31'b0, i_rvalid[1]}, 0);
    tick(); settle();
    check("pr_c4_i_rvalid",{31'b0, i_rvalid[1]}, 1);
    check("pr_c4_d_rvalid",{31'b0, d_rvalid[1]}, 0);
    tick();

    // Store, MEM_LAT=2
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h2000; d_wdata[1] = 32'h3a;
    settle();
    check("st_c0_d_ready", {31'b0, d_ready[1]}, 1);
    check("st_c0_m_we",    {31'b0, m_we[1]},    1);
    check("st_c0_m_wdata", m_wdata[1], 32'h3a);
    check("st_c0_m_addr",  m_addr[1],  32'h2000);
    tick(); d_req[1] = 1'b0; d_we[1] = 1'b0; settle();
    check("st_c1_m_we",    {31'b0, m_we[1]},     0);
    check("st_c1_m_wdata", m_wdata[1], 0);
    check("st_c1_d_rvalid",{31'b0, d_rvalid[1]}, 0);
    check("st_c1_i_rvalid",{31'b0, i_rvalid[1]}, 0);
    tick(); settle();
    check("st_c2_d_rvalid",{31'b0, d_rvalid[1]}, 1);
    check("st_c2_i_rvalid",{31'b0, i_rvalid[1]}, 0);
    tick();

    // Starvation guard, MEM_LAT=1, STARVE_MAX=4: D,D,D,D,I repeating
    i_req[0] = 1'b1; i_addr[0] = 32'h100;
    d_req[0] = 1'b1; d_addr[0] = 32'h200;
    begin
      logic prev_d;
      prev_d = 1'b0;
      for (int n = 0; n < 10; n++) begin
        settle();
        check($sformatf("sv_grant%0d", n), {30'b0, i_ready[0], d_ready[0]},
              (n % 5 == 4) ? 32'd2 : 32'd1);
        if (n > 0)
          check($sformatf("sv_dvalid%0d", n), {31'b0, d_rvalid[0]}, {31'b0, prev_d});
        prev_d = (n % 5 != 4);
        tick();
      end
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    tick(); tick();

    // Reset abort, MEM_LAT=3
    i_req[2] = 1'b1; i_addr[2] = 32'h80; m_rdata[2] = 32'h5555_aaaa;
    settle();
    check("ra_c0_i_ready", {31'b0, i_ready[2]}, 1);
    tick(); i_req[2] = 1'b0; reset = 1'b0; settle();
    check("ra_c1_busy",    {31'b0, busy[2]},     0);
    check("ra_c1_i_rvalid",{31'b0, i_rvalid[2]}, 0);
    tick(); reset = 1'b1; settle();
    check("ra_c2_i_rvalid",{31'b0, i_rvalid[2]}, 0);
    check("ra_c2_busy",    {31'b0, busy[2]},     0);
    tick(); settle();
    check("ra_c3_i_rvalid",{31'b0, i_rvalid[2]}, 0);
    tick(); i_req[2] = 1'b1; i_addr[2] = 32'hC0; settle();
    check("ra_c4_i_ready", {31'b0, i_ready[2]}, 1);
    check("ra_c4_m_addr",  m_addr[2], 32'hC0);
    tick(); i_req[2] = 1'b0; settle();
    check("ra_c5_i_rvalid",{31'b0, i_rvalid[2]}, 0);
    tick(); settle();
    check("ra_c6_i_rvalid",{31'b0, i_rvalid[2]}, 0);
    tick(); settle();
    check("ra_c7_i_rvalid",{31'b0, i_rvalid[2]}, 1);
    check("ra_c7_i_rdata", i_rdata[2], 32'h5555_aaaa);
    tick();

    // Streaming fetch, MEM_LAT=1
    for (int n = 0; n < 3; n++) begin
      i_req[0] = 1'b1; i_addr[0] = 32'(n * 4);
      settle();
      check($sformatf("sf_ready%0d", n), {31'b0, i_ready[0]}, 1);
      check($sformatf("sf_addr%0d", n),  m_addr[0], 32'(n * 4));
      check($sformatf("sf_rvalid%0d", n), {31'b0, i_rvalid[0]}, (n > 0) ? 32'd1 : 32'd0);
      tick();
    end
    i_req[0] = 1'b0; settle();
    check("sf_rvalid3", {31'b0, i_rvalid[0]}, 1);
    check("sf_ready3",  {31'b0, i_ready[0]},  0);
    tick(); settle();
    check("sf_rvalid4", {31'b0, i_rvalid[0]}, 0);
    check("sf_busy4",   {31'b0, busy[0]},     0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single unified memory port between the instruction-fetch path and the load/store path of `execution`. This replaces the current assumption that fetch and data access hit memory in the same cycle. The block grants one requester per transaction and counts out a fixed memory read latency. It returns read data or write completion to the owner, and enforces data-over-fetch priority with a starvation guard so fetch always progresses.

## Interface
- `AW`, 32, address width (byte address, passed through unmodified)
- `DW`, 32, data width
- `MEM_LAT`, 2, memory latency in cycles from `m_en` to valid `m_rdata` / write done; legal range 1..7
- `STARVE_MAX`, 4, maximum consecutive data grants while fetch is waiting; legal range 1..15

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_ready`
- `i_addr`  in  AW  fetch address
- `i_ready`  out  1  fetch accepted this cycle (1-cycle pulse)
- `i_rvalid`  out  1  fetch data valid this cycle (1-cycle pulse)
- `i_rdata`  out  DW  fetch data, meaningful only with `i_rvalid`
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ready`  out  1  data accepted this cycle (1-cycle pulse)
- `d_rvalid`  out  1  load data valid or store complete (1-cycle pulse)
- `d_rdata`  out  DW  load data, meaningful only with `d_rvalid` and a load
- `m_en`, `m_we`  out  1  memory access strobe and write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after `m_en`
- `busy`  out  1  transaction outstanding (state WAIT)

## Operation
- State machine has two states.
  - IDLE: no transaction outstanding.
  - WAIT: a transaction is outstanding. It has a latency counter `cnt` (3 bits), an owner flag `own` (I or D) and a latched `we`.
- Grant slot: any cycle in IDLE, or the completion cycle (WAIT with `cnt==1`). In a grant slot with any request pending:
  - Pick a winner.
  - Assert `m_en` and the winner's `*_ready`.
  - Drive `m_we`/`m_addr`/`m_wdata` from the winner.
  - Load `cnt=MEM_LAT`, set `own`, latch `we`, and go to WAIT.
  - With no request in a grant slot, go to or stay in IDLE.
- Winner selection:
  - Only one requester: that requester wins.
  - Both requesting: D wins unless `streak==STARVE_MAX`, in which case I wins.
  - `streak` (4 bits) increments on a D grant while `i_req` is high. It clears on any I grant, or on a D grant while `i_req` is low.
- In WAIT with `cnt>1`, decrement `cnt` each cycle. No grants are issued.
- Completion cycle (WAIT, `cnt==1`): pulse `i_rvalid` or `d_rvalid` per `own`.
- `i_rdata`/`d_rdata` pass `m_rdata` through combinationally. A store completion pulses `d_rvalid`, and `d_rdata` is don't-care.
- When `m_en=0`, `m_we`, `m_addr` and `m_wdata` are driven to 0.
- At most one transaction is outstanding. The memory sees one access per grant.
- Reset (asynchronous, any time): go to IDLE with `cnt=0`, `streak=0`, `own=I`. An aborted transaction never produces `rvalid`, and a memory response arriving after reset is ignored.
- Reset values (reset low, requests low): all `*_ready`, `*_rvalid`, `m_en`, `m_we` and `busy` are 0; `m_addr` and `m_wdata` are 0.

## Timing
- Grant at cycle t means completion pulse at t+`MEM_LAT`.
- Back-to-back throughput is one transaction per `MEM_LAT` cycles, because a new grant may coincide with the previous completion. With `MEM_LAT=1`, one transaction per cycle.
- `*_ready`, `m_*` and `*_rvalid` are combinational from registered state plus the current requests. There is no added latency beyond `MEM_LAT`.
- A request dropped before its `ready` is legal and simply never granted. A request must not change its address or data while it is held.

## Structure
- Package `mem_arb_pkg`:
  - state enum `{ST_IDLE, ST_WAIT}`
  - owner enum `{OWN_I, OWN_D}`
  - counter widths
- Sub-module `mem_arb_picker`: combinational winner selection from `i_req`, `d_req`, `streak` and `STARVE_MAX`. Outputs are `grant_i`, `grant_d` and `streak_next`.
- Top-level `mem_port_arbiter` holds the FSM, `cnt`, `own`, latched `we`, `streak` and the port muxing.

## Test plan
- `MEM_LAT=2`, `i_req` at cycle 0 with `i_addr=0x0`, memory returns 0x20020005: expect `i_ready` and `m_en=1`, `m_addr=0x0` at cycle 0; `i_rvalid=1`, `i_rdata=0x20020005` at cycle 2; `busy` high in cycles 1–2.
- `MEM_LAT=2`, `i_req` and `d_req` (load 0x1000) rise together: expect D granted at cycle 0 with `d_rvalid` at cycle 2; I granted at cycle 2 with `i_rvalid` at cycle 4.
- `MEM_LAT=1`, `STARVE_MAX=4`, `i_req` and `d_req` held for 10 grants: expect grant order D,D,D,D,I,D,D,D,D,I.
- Store with `d_we=1`, `d_addr=0x2000`, `d_wdata=0x3a`: expect `m_we=1`, `m_wdata=0x3a` on the grant cycle and `d_rvalid` `MEM_LAT` cycles later; `i_rvalid` never fires.
- `MEM_LAT=3`: pull `reset` low one cycle after a fetch grant. Expect `busy=0` and no `i_rvalid`; after release, a new `i_req` is granted immediately and its `i_rvalid` arrives 3 cycles later.
- `MEM_LAT=1`, `i_req` held with addresses 0x0, 0x4, 0x8: expect `i_ready` every cycle and `i_rvalid` at cycles 1, 2, 3.
